// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - multi-cycle popcount sequencer with binarized activation output
// One shared popcount1 counts a VWIDTH-bit chunk per cycle; the chunk counts are summed into the result.

module popcount1 #(
  parameter int VWIDTH = 8,
  parameter int CWIDTH = 4
) (
  input  logic [VWIDTH-1:0] vec,
  output logic [CWIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < VWIDTH; i++) begin
      count = count + CWIDTH'(vec[i]);
    end
  end

endmodule

module popcount_seq #(
  parameter int TOTAL  = 64,
  parameter int VWIDTH = 8,
  parameter int CWIDTH = 4,
  parameter int AWIDTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TOTAL-1:0]  in_vec,
  input  logic [AWIDTH-1:0] threshold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] out_count,
  output logic              out_bit
);

  localparam int NCHUNK = TOTAL / VWIDTH;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [TOTAL-1:0]  shreg;
  logic [AWIDTH-1:0] thr_q;
  logic [AWIDTH-1:0] acc;
  logic [IW-1:0]     idx;
  logic [CWIDTH-1:0] chunk_count;
  logic [AWIDTH-1:0] sum;

  // The low chunk of the shift register is always the chunk at the current index.
  popcount1 #(
    .VWIDTH (VWIDTH),
    .CWIDTH (CWIDTH)
  ) u_popcount1 (
    .vec   (shreg[VWIDTH-1:0]),
    .count (chunk_count)
  );

  assign sum = acc + AWIDTH'(chunk_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      thr_q     <= '0;
      acc       <= '0;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_bit   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            shreg    <= in_vec;
            thr_q    <= threshold;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= sum;
          idx   <= idx + IW'(1);
          shreg <= shreg >> VWIDTH;
          // Result registers load from the final sum so they appear with out_valid.
          if (idx == IW'(NCHUNK - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_count <= sum;
            out_bit   <= (sum >= thr_q);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - directed table-driven bench for popcount_seq
// Covers reset, result values, latency, backpressure, input isolation and mid-run reset.

module tb_popcount_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vec;
  logic [6:0]  threshold;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        out_bit;

  int checks   = 0;
  int failures = 0;

  popcount_seq #(
    .TOTAL  (64),
    .VWIDTH (8),
    .CWIDTH (4),
    .AWIDTH (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .threshold (threshold),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_bit   (out_bit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] vec;
    logic [6:0]  thr;
    int          bp;
    logic [6:0]  exp_count;
    logic        exp_bit;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_job(input logic [63:0] v, input logic [6:0] t, input int bp,
                        output logic [6:0] cnt, output logic b, output int lat);
    int n;
    lat = -1;
    cnt = '0;
    b   = 1'b0;
    n   = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      return;
    end
    in_vec    = v;
    threshold = t;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = 1'b0;
    in_vec    = '0;
    threshold = '0;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("valid_timeout", 64'd0, 64'd1);
      return;
    end
    lat = n;
    cnt = out_count;
    b   = out_bit;
    check("valid_ready_excl", in_ready, 1'b0);
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_count", out_count, cnt);
      check("bp_bit", out_bit, b);
      check("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 1'b0);
    check("post_hs_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [6:0] cnt;
    logic       b;
    int         lat;
    int         n;
    logic       bad_ready;
    logic       saw_valid;

    tbl[0] = '{64'h0000_0000_0000_0000, 7'd1,   0, 7'd0,  1'b0};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64,  0, 7'd64, 1'b1};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd127, 0, 7'd64, 1'b0};
    tbl[3] = '{64'h5555_5555_5555_5555, 7'd32,  0, 7'd32, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0001, 7'd3,   0, 7'd2,  1'b0};
    tbl[5] = '{64'h0F0F_0F0F_0F0F_0F0F, 7'd33,  5, 7'd32, 1'b0};
    tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd0,   0, 7'd64, 1'b1};
    tbl[7] = '{64'h0000_0000_0000_0001, 7'd1,   0, 7'd1,  1'b1};
    tbl[8] = '{64'h8000_0000_0000_0000, 7'd2,   2, 7'd1,  1'b0};
    tbl[9] = '{64'h1234_5678_9ABC_DEF0, 7'd32,  0, 7'd32, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_vec    = '0;
    threshold = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_count", out_count, 7'd0);
    check("rst_out_bit", out_bit, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_job(tbl[i].vec, tbl[i].thr, tbl[i].bp, cnt, b, lat);
      check($sformatf("tbl%0d_latency", i), lat, 9);
      check($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_count);
      check($sformatf("tbl%0d_bit", i), b, tbl[i].exp_bit);
    end

    // Input isolation: inputs change and in_valid stays high during RUN/DONE.
    in_vec    = 64'h0000_0000_0000_00FF;
    threshold = 7'd8;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("iso_in_ready_at_accept", in_ready, 1'b1);
    @(negedge clk);
    in_vec    = 64'hFFFF_FFFF_FFFF_FFFF;
    threshold = 7'd0;
    bad_ready = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      if (in_ready) bad_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    check("iso_latency", n, 9);
    check("iso_ready_low_in_run", bad_ready, 1'b0);
    check("iso_count", out_count, 7'd8);
    check("iso_bit", out_bit, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("iso_hold_in_ready", in_ready, 1'b0);
      check("iso_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("iso_second_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("iso_second_accepted", in_ready, 1'b0);
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("iso2_latency", n, 9);
    check("iso2_count", out_count, 7'd64);
    check("iso2_bit", out_bit, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("iso2_post_hs_valid", out_valid, 1'b0);

    // Reset asserted in RUN cycle 4; out_count still holds 64 from the last job.
    in_vec    = 64'h0000_0000_0000_FFFF;
    threshold = 7'd4;
    in_valid  = 1'b1;
    check("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_count", out_count, 7'd0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_out_bit", out_bit, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_valid", saw_valid, 1'b0);
    do_job(64'h0000_0000_0000_00FF, 7'd8, 0, cnt, b, lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_count", cnt, 7'd8);
    check("post_rst_bit", b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
